multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Control FSM for the multi-cycle MIPS datapath. One instruction is sequenced per
//  pass: FETCH, DECODE, EXEC, MEM, WB. The FSM drives the PC/IR write enables,
//  memory requests, ALU operand muxes, ALU_op and register-file controls.
//  Sits between the IR opcode field and the shared instruction/data memory port.
//  It waits on a memory ready handshake, with a timeout.
// PARAMETERS
//  TO_CYCLES  15  max consecutive wait cycles with mem_ready_i low before bus error (>=2)
//  CNT_W      4   width of timeout counter; 2^CNT_W > TO_CYCLES
// PORTS
//  clk_i           in   1  clock, rising edge
//  rst_i           in   1  reset, asynchronous, active-high
//  instr_op_i      in   6  IR[31:26]; stable except on the ir_write_o edge
//  mem_ready_i     in   1  memory completes the current request this cycle
//  mem_req_o       out  1  memory request; held until mem_ready_i
//  mem_we_o        out  1  memory write; valid with mem_req_o
//  iord_o          out  1  memory address: 0=PC, 1=ALUOut
//  ir_write_o      out  1  load IR
//  pc_write_o      out  1  unconditional PC load
//  pc_write_cond_o out  1  PC load if ALU zero (beq)
//  pc_src_o        out  2  0=ALU result, 1=ALUOut (branch target), 2=jump target
//  alu_src_a_o     out  1  0=PC, 1=rs
//  alu_src_b_o     out  2  0=rt, 1=const 4, 2=sign-ext imm, 3=imm<<2
//  ALU_op_o        out  3  0=R-type (funct-decoded), 2=add, 5=sub/compare, 7=sltiu
//  RegWrite_o      out  1  register file write
//  RegDst_o        out  1  0=rt, 1=rd
//  MemtoReg_o      out  1  0=ALUOut, 1=MDR
//  illegal_o       out  1  sticky: unsupported opcode decoded
//  bus_err_o       out  1  sticky: memory timeout
//  state_o         out  4  current state encoding (debug)
// BEHAVIOUR
//  - States/encoding: IDLE=0 FETCH=1 DECODE=2 MEM_ADDR=3 MEM_RD=4 MEM_WB=5 MEM_WR=6
//    EXEC_R=7 R_WB=8 EXEC_I=9 I_WB=10 BRANCH=11 JUMP=12 HALT=13.
//    Encodings 14-15 -> IDLE.
//  - Reset: state=IDLE, timeout cnt=0, illegal_o=0, bus_err_o=0.
//    Every output is 0 while in IDLE; outputs drop asynchronously with rst_i.
//  - Output decoding: outputs decode from state. Exception: ir_write_o and pc_write_o
//    in FETCH are also gated by mem_ready_i. Any output not listed for a state is 0.
//  - IDLE: go to FETCH unconditionally.
//  - FETCH: mem_req=1, iord=0, a=0, b=1, op=2, pc_src=0.
//    With mem_ready_i: ir_write=pc_write=1 for exactly that cycle, then go to DECODE.
//  - DECODE: a=0, b=3, op=2 (branch target into ALUOut). Next state by opcode:
//    0->EXEC_R, 35(lw)->MEM_ADDR, 43(sw)->MEM_ADDR, 8(addi)->EXEC_I, 9(sltiu)->EXEC_I,
//    4(beq)->BRANCH, 2(j)->JUMP, other->HALT and illegal_o set to 1.
//  - MEM_ADDR: a=1, b=2, op=2. Next is MEM_RD if opcode is 35, else MEM_WR.
//  - MEM_RD: mem_req=1, iord=1; wait for ready, then MEM_WB.
//  - MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1; then FETCH.
//  - MEM_WR: mem_req=1, mem_we=1, iord=1; wait for ready, then FETCH.
//  - EXEC_R: a=1, b=0, op=0; then R_WB. R_WB: RegWrite=1, RegDst=1; then FETCH.
//  - EXEC_I: a=1, b=2, op=2 (addi) or 7 (sltiu); then I_WB.
//    I_WB: RegWrite=1, RegDst=0; then FETCH.
//  - BRANCH: a=1, b=0, op=5, pc_write_cond=1, pc_src=1; then FETCH.
//  - JUMP: pc_write=1, pc_src=2; then FETCH.
//  - HALT: all strobes 0; remain in HALT until rst_i.
//  - Latency with zero wait states: R/addi/sltiu=4 cycles, lw=5, sw=4, beq=3, j=3.
//  - Timeout: wait states are FETCH, MEM_RD and MEM_WR.
//    cnt clears on entry to each wait state and increments each cycle mem_ready_i=0.
//    If cnt==TO_CYCLES-1 and mem_ready_i=0: next state=HALT, bus_err_o set to 1.
//    If mem_ready_i rises on that same cycle, ready wins and there is no error.
//  - Never drive mem_req_o and RegWrite_o in the same cycle.
//    At most one of pc_write_o / pc_write_cond_o is high.
// TESTING
//  1 rst_i pulse -> all outputs 0 and state_o=0 during reset.
//    First edge after release -> state_o=1, mem_req_o=1, iord_o=0.
//  2 lw (op 35), mem_ready_i low 3 cycles in FETCH -> ir_write_o/pc_write_o high exactly
//    1 cycle. States 1,1,1,1,2,3,4,5,1. RegWrite_o=1 with MemtoReg_o=1 in state 5 only.
//  3 beq (op 4), ready immediate -> states 1,2,11,1.
//    In state 11: ALU_op_o=5, pc_write_cond_o=1, pc_src_o=1, pc_write_o=0.
//  4 op 0x3F -> DECODE then HALT, illegal_o=1.
//    mem_req_o stays 0 for 20 further cycles; rst_i recovers to IDLE.
//  5 sw (op 43), mem_ready_i held low in MEM_WR -> HALT after 15 wait cycles, bus_err_o=1.
//    Repeat with ready on the 15th cycle -> no error, return to FETCH.
//  6 rst_i asserted mid-cycle in MEM_WR -> mem_we_o/mem_req_o fall before the next edge.
//    IDLE, then FETCH; sticky flags cleared.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multi-cycle MIPS control FSM and its
// datapath / shared memory port. The controller takes the master side.
interface multicycle_ctrl_if;
  logic [5:0] instr_op_i;
  logic       mem_ready_i;
  logic       mem_req_o;
  logic       mem_we_o;
  logic       iord_o;
  logic       ir_write_o;
  logic       pc_write_o;
  logic       pc_write_cond_o;
  logic [1:0] pc_src_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] ALU_op_o;
  logic       RegWrite_o;
  logic       RegDst_o;
  logic       MemtoReg_o;
  logic       illegal_o;
  logic       bus_err_o;
  logic [3:0] state_o;

  modport master (
    input  instr_op_i, mem_ready_i,
    output mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_write_cond_o,
           pc_src_o, alu_src_a_o, alu_src_b_o, ALU_op_o, RegWrite_o, RegDst_o,
           MemtoReg_o, illegal_o, bus_err_o, state_o
  );

  modport slave (
    output instr_op_i, mem_ready_i,
    input  mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_write_cond_o,
           pc_src_o, alu_src_a_o, alu_src_b_o, ALU_op_o, RegWrite_o, RegDst_o,
           MemtoReg_o, illegal_o, bus_err_o, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback per
// instruction, with a memory-ready timeout that parks the machine in HALT.
module multicycle_ctrl #(
  parameter int TO_CYCLES = 15,
  parameter int CNT_W     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYCLES - 1);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_illegal, r_bus_err;
  logic             w_wait, w_timeout, w_bad_op;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counter restarts whenever the state changes, so each wait state sees it at 0 on entry
      if (w_next != r_state)             r_cnt <= '0;
      else if (w_wait && !bus.mem_ready_i) r_cnt <= r_cnt + CNT_W'(1);
      r_illegal <= r_illegal | w_bad_op;
      r_bus_err <= r_bus_err | w_timeout;
    end
  end

  always_comb begin
    w_next              = r_state;
    w_wait              = 1'b0;
    w_timeout           = 1'b0;
    w_bad_op            = 1'b0;
    bus.mem_req_o       = 1'b0;
    bus.mem_we_o        = 1'b0;
    bus.iord_o          = 1'b0;
    bus.ir_write_o      = 1'b0;
    bus.pc_write_o      = 1'b0;
    bus.pc_write_cond_o = 1'b0;
    bus.pc_src_o        = 2'd0;
    bus.alu_src_a_o     = 1'b0;
    bus.alu_src_b_o     = 2'd0;
    bus.ALU_op_o        = 3'd0;
    bus.RegWrite_o      = 1'b0;
    bus.RegDst_o        = 1'b0;
    bus.MemtoReg_o      = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        w_wait          = 1'b1;
        bus.mem_req_o   = 1'b1;
        bus.alu_src_b_o = 2'd1;
        bus.ALU_op_o    = 3'd2;
        if (bus.mem_ready_i) begin
          bus.ir_write_o = 1'b1;
          bus.pc_write_o = 1'b1;
          w_next         = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.alu_src_b_o = 2'd3;
        bus.ALU_op_o    = 3'd2;
        case (bus.instr_op_i)
          6'd0:        w_next = S_EXEC_R;
          6'd35, 6'd43: w_next = S_MEM_ADDR;
          6'd8, 6'd9:  w_next = S_EXEC_I;
          6'd4:        w_next = S_BRANCH;
          6'd2:        w_next = S_JUMP;
          default: begin
            w_next   = S_HALT;
            w_bad_op = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_src_b_o = 2'd2;
        bus.ALU_op_o    = 3'd2;
        w_next          = (bus.instr_op_i == 6'd35) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        w_wait        = 1'b1;
        bus.mem_req_o = 1'b1;
        bus.iord_o    = 1'b1;
        if (bus.mem_ready_i) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        bus.RegWrite_o = 1'b1;
        bus.MemtoReg_o = 1'b1;
        w_next         = S_FETCH;
      end
      S_MEM_WR: begin
        w_wait        = 1'b1;
        bus.mem_req_o = 1'b1;
        bus.mem_we_o  = 1'b1;
        bus.iord_o    = 1'b1;
        if (bus.mem_ready_i) w_next = S_FETCH;
      end
      S_EXEC_R: begin
        bus.alu_src_a_o = 1'b1;
        w_next          = S_R_WB;
      end
      S_R_WB: begin
        bus.RegWrite_o = 1'b1;
        bus.RegDst_o   = 1'b1;
        w_next         = S_FETCH;
      end
      S_EXEC_I: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_src_b_o = 2'd2;
        bus.ALU_op_o    = (bus.instr_op_i == 6'd9) ? 3'd7 : 3'd2;
        w_next          = S_I_WB;
      end
      S_I_WB: begin
        bus.RegWrite_o = 1'b1;
        w_next         = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a_o     = 1'b1;
        bus.ALU_op_o        = 3'd5;
        bus.pc_write_cond_o = 1'b1;
        bus.pc_src_o        = 2'd1;
        w_next              = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_write_o = 1'b1;
        bus.pc_src_o   = 2'd2;
        w_next         = S_FETCH;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
    // Ready on the last allowed cycle wins over the timeout
    if (w_wait && !bus.mem_ready_i && r_cnt == TO_LAST) begin
      w_next    = S_HALT;
      w_timeout = 1'b1;
    end
  end

  assign bus.illegal_o = r_illegal;
  assign bus.bus_err_o = r_bus_err;
  assign bus.state_o   = r_state;

endmodule
